// File: rtl/flp32_pkg.sv
// Shared flp32 definitions for the complex accumulator and its adders.
package flp32_pkg;

    localparam int unsigned FLP32_W = 32;
    localparam logic [FLP32_W-1:0] FLP32_ZERO = 32'h00000000;
    localparam logic [FLP32_W-1:0] FLP32_QNAN = 32'h7FC00000;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } cacc_state_t;

endpackage

// File: rtl/flp32_add_sub.sv
// Combinational IEEE-754 single-precision adder/subtractor, round-to-nearest-even,
// with subnormal support and NaN/Inf propagation.
module flp32_add_sub
    import flp32_pkg::*;
(
    input  logic [FLP32_W-1:0] a_i,
    input  logic [FLP32_W-1:0] b_i,
    input  logic               sub_i,
    output logic [FLP32_W-1:0] y_o
);

    logic        sa, sb, sl, ss;
    logic        a_nan, b_nan, a_inf, b_inf, sticky, rnd;
    logic [9:0]  ea, eb, el, es, d, e;
    logic [23:0] ml, ms;
    logic [26:0] aligned;
    logic [27:0] sum;
    logic [24:0] mr;

    always_comb begin
        sa    = a_i[31];
        sb    = b_i[31] ^ sub_i;
        a_nan = (&a_i[30:23]) && (|a_i[22:0]);
        b_nan = (&b_i[30:23]) && (|b_i[22:0]);
        a_inf = (&a_i[30:23]) && !(|a_i[22:0]);
        b_inf = (&b_i[30:23]) && !(|b_i[22:0]);
        // Subnormals use exponent 1 with no hidden bit.
        ea = (a_i[30:23] == 8'd0) ? 10'd1 : {2'b00, a_i[30:23]};
        eb = (b_i[30:23] == 8'd0) ? 10'd1 : {2'b00, b_i[30:23]};

        if (b_i[30:0] > a_i[30:0]) begin
            sl = sb; el = eb; ml = {|b_i[30:23], b_i[22:0]};
            ss = sa; es = ea; ms = {|a_i[30:23], a_i[22:0]};
        end else begin
            sl = sa; el = ea; ml = {|a_i[30:23], a_i[22:0]};
            ss = sb; es = eb; ms = {|b_i[30:23], b_i[22:0]};
        end

        d = el - es;
        if (d > 10'd26) begin
            aligned = 27'd0;
            sticky  = |ms;
        end else begin
            aligned = {ms, 3'b000} >> d;
            sticky  = |({ms, 3'b000} & ((27'd1 << d) - 27'd1));
        end
        aligned[0] = aligned[0] | sticky;

        if (sl == ss) sum = {1'b0, ml, 3'b000} + {1'b0, aligned};
        else          sum = {1'b0, ml, 3'b000} - {1'b0, aligned};

        e = el;
        if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            e   = e + 10'd1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!sum[26] && e > 10'd1) begin
                sum = sum << 1;
                e   = e - 10'd1;
            end
        end

        rnd = sum[2] && (sum[1] || sum[0] || sum[3]);
        mr  = {1'b0, sum[26:3]} + {24'd0, rnd};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'd1;
        end

        if (e >= 10'd255) y_o = {sl, 8'hFF, 23'd0};
        else              y_o = {sl, mr[23] ? e[7:0] : 8'h00, mr[22:0]};

        if (sum == 28'd0)                                y_o = {sl & ss, 31'd0};
        if (a_nan || b_nan || (a_inf && b_inf && sa != sb)) y_o = FLP32_QNAN;
        else if (a_inf)                                  y_o = {sa, 8'hFF, 23'd0};
        else if (b_inf)                                  y_o = {sb, 8'hFF, 23'd0};
    end

endmodule

// File: rtl/flp32_complex_adder.sv
// Combinational complex flp32 adder: z = x0 + y0, component-wise.
module flp32_complex_adder
    import flp32_pkg::*;
(
    input  logic [FLP32_W-1:0] x0_re_i,
    input  logic [FLP32_W-1:0] x0_im_i,
    input  logic [FLP32_W-1:0] y0_re_i,
    input  logic [FLP32_W-1:0] y0_im_i,
    output logic [FLP32_W-1:0] z_re_o,
    output logic [FLP32_W-1:0] z_im_o
);

    flp32_add_sub u_add_re (
        .a_i   (x0_re_i),
        .b_i   (y0_re_i),
        .sub_i (1'b0),
        .y_o   (z_re_o)
    );

    flp32_add_sub u_add_im (
        .a_i   (x0_im_i),
        .b_i   (y0_im_i),
        .sub_i (1'b0),
        .y_o   (z_im_o)
    );

endmodule

// File: rtl/flp32_complex_accumulator.sv
// Sums a block of flp32 complex products and presents the total with a valid/ready handshake.
// Optional abort input enabled by defining FLP32_CACC_ABORT_EN.
module flp32_complex_accumulator
    import flp32_pkg::*;
#(
    parameter int unsigned LEN_W = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FLP32_W-1:0] in_real,
    input  logic [FLP32_W-1:0] in_imag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FLP32_W-1:0] out_real,
    output logic [FLP32_W-1:0] out_imag,
    output logic               busy
`ifdef FLP32_CACC_ABORT_EN
    ,
    input  logic               abort
`endif
);

    cacc_state_t        state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [FLP32_W-1:0] acc_real_q, acc_real_d, acc_imag_q, acc_imag_d;
    logic [FLP32_W-1:0] sum_real, sum_imag;

    flp32_complex_adder u_adder (
        .x0_re_i (acc_real_q),
        .x0_im_i (acc_imag_q),
        .y0_re_i (in_real),
        .y0_im_i (in_imag),
        .z_re_o  (sum_real),
        .z_im_o  (sum_imag)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        acc_real_d  = acc_real_q;
        acc_imag_d  = acc_imag_q;
        in_ready    = (state_q == ACC);
        out_valid   = (state_q == DONE);
        busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    remaining_d = len;
                    acc_real_d  = FLP32_ZERO;
                    acc_imag_d  = FLP32_ZERO;
                    state_d     = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (in_valid) begin
                    acc_real_d  = sum_real;
                    acc_imag_d  = sum_imag;
                    remaining_d = remaining_q - 1'b1;
                    if (remaining_q == LEN_W'(1)) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

`ifdef FLP32_CACC_ABORT_EN
        // Abort wins over any handshake in the same cycle.
        if (abort && state_q != IDLE) begin
            state_d     = IDLE;
            remaining_d = '0;
            acc_real_d  = FLP32_ZERO;
            acc_imag_d  = FLP32_ZERO;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            acc_real_q  <= FLP32_ZERO;
            acc_imag_q  <= FLP32_ZERO;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            acc_real_q  <= acc_real_d;
            acc_imag_q  <= acc_imag_d;
        end
    end

    assign out_real = acc_real_q;
    assign out_imag = acc_imag_q;

endmodule

// File: tb/tb_flp32_complex_accumulator.sv
// Directed self-checking bench for flp32_complex_accumulator.
module tb_flp32_complex_accumulator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_real = '0;
    logic [31:0] in_imag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_real;
    logic [31:0] out_imag;
    logic        busy;
`ifdef FLP32_CACC_ABORT_EN
    logic        abort = 1'b0;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    flp32_complex_accumulator #(.LEN_W(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_real   (in_real),
        .in_imag   (in_imag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_real  (out_real),
        .out_imag  (out_imag),
        .busy      (busy)
`ifdef FLP32_CACC_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    // Drive helpers: called at a negedge, return at the following negedge.
    task automatic start_block(input logic [9:0] l);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(input logic [31:0] re, input logic [31:0] im);
        in_valid = 1'b1;
        in_real  = re;
        in_imag  = im;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++;
        if ({busy, in_ready, out_valid} !== 3'b000)
            $display("FAIL reset_flags: got %b want 000", {busy, in_ready, out_valid});
        else pass_cnt++;
        total_cnt++;
        if (out_real !== 32'h0) $display("FAIL reset_real: got %h want 00000000", out_real);
        else pass_cnt++;
        total_cnt++;
        if (out_imag !== 32'h0) $display("FAIL reset_imag: got %h want 00000000", out_imag);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1;  // ignored while idle
        @(negedge clk);
        in_valid = 1'b0;
        total_cnt++;
        if ({busy, in_ready} !== 2'b00)
            $display("FAIL idle_ignores_valid: got %b want 00", {busy, in_ready});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        start_block(10'd3);
        total_cnt++;
        if ({busy, in_ready, out_valid} !== 3'b110)
            $display("FAIL b2b_accept: got %b want 110", {busy, in_ready, out_valid});
        else pass_cnt++;
        push(32'h3F800000, 32'h40000000);
        push(32'h40000000, 32'hBF800000);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL b2b_early_valid: got %b want 0", out_valid);
        else pass_cnt++;
        push(32'h3F000000, 32'h3F000000);
        total_cnt++;
        if ({out_valid, in_ready} !== 2'b10)
            $display("FAIL b2b_done: got %b want 10", {out_valid, in_ready});
        else pass_cnt++;
        total_cnt++;
        if (out_real !== 32'h40600000) $display("FAIL b2b_real: got %h want 40600000", out_real);
        else pass_cnt++;
        total_cnt++;
        if (out_imag !== 32'h3FC00000) $display("FAIL b2b_imag: got %h want 3fc00000", out_imag);
        else pass_cnt++;
        pop();
        total_cnt++;
        if ({busy, out_valid} !== 2'b00)
            $display("FAIL b2b_idle: got %b want 00", {busy, out_valid});
        else pass_cnt++;
    endtask

    task automatic test_len_zero();
        start_block(10'd0);
        total_cnt++;
        if ({out_valid, in_ready, busy} !== 3'b101)
            $display("FAIL len0_done: got %b want 101", {out_valid, in_ready, busy});
        else pass_cnt++;
        total_cnt++;
        if ({out_real, out_imag} !== 64'h0)
            $display("FAIL len0_zero: got %h want 0", {out_real, out_imag});
        else pass_cnt++;
        pop();
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL len0_idle: got %b want 0", busy);
        else pass_cnt++;
        start_block(10'd0);
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL len0_restart: got %b want 1", out_valid);
        else pass_cnt++;
        pop();
    endtask

    task automatic test_gaps_backpressure();
        start_block(10'd2);
        for (int p = 0; p < 2; p++) begin
            push(32'h3F800000, 32'h3F800000);
            if (p == 0) begin
                for (int g = 0; g < 3; g++) begin
                    total_cnt++;
                    if ({out_valid, in_ready} !== 2'b01)
                        $display("FAIL gap_hold[%0d]: got %b want 01", g, {out_valid, in_ready});
                    else pass_cnt++;
                    @(negedge clk);
                end
            end
        end
        for (int c = 0; c < 5; c++) begin
            start = 1'b1;  // must be ignored during DONE
            len   = 10'd1;
            total_cnt++;
            if (out_valid !== 1'b1 || out_real !== 32'h40000000 || out_imag !== 32'h40000000)
                $display("FAIL held_result[%0d]: got %b %h %h want 1 40000000 40000000",
                         c, out_valid, out_real, out_imag);
            else pass_cnt++;
            @(negedge clk);
        end
        start = 1'b0;
        pop();
        @(negedge clk);
        total_cnt++;
        if ({busy, in_ready, out_valid} !== 3'b000)
            $display("FAIL start_not_queued: got %b want 000", {busy, in_ready, out_valid});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_block();
        start_block(10'd4);
        push(32'h3F800000, 32'h3F800000);
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, in_ready, out_valid} !== 3'b000 || out_real !== 32'h0 || out_imag !== 32'h0)
            $display("FAIL async_reset: got %b %h %h want 000 0 0",
                     {busy, in_ready, out_valid}, out_real, out_imag);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        start_block(10'd1);
        push(32'h40400000, 32'hBF800000);
        total_cnt++;
        if (out_valid !== 1'b1 || out_real !== 32'h40400000 || out_imag !== 32'hBF800000)
            $display("FAIL post_reset_block: got %b %h %h want 1 40400000 bf800000",
                     out_valid, out_real, out_imag);
        else pass_cnt++;
        pop();
    endtask

    task automatic test_consecutive();
        start_block(10'd1);
        push(32'h3F800000, 32'h00000000);
        total_cnt++;
        if (out_real !== 32'h3F800000 || out_imag !== 32'h0)
            $display("FAIL consec_first: got %h %h want 3f800000 00000000", out_real, out_imag);
        else pass_cnt++;
        pop();
        start_block(10'd1);
        push(32'h40000000, 32'h00000000);
        total_cnt++;
        if (out_valid !== 1'b1 || out_real !== 32'h40000000 || out_imag !== 32'h0)
            $display("FAIL consec_second: got %b %h %h want 1 40000000 00000000",
                     out_valid, out_real, out_imag);
        else pass_cnt++;
        pop();
    endtask

`ifdef FLP32_CACC_ABORT_EN
    task automatic test_abort();
        start_block(10'd4);
        push(32'h3F800000, 32'h3F800000);
        push(32'h3F800000, 32'h3F800000);
        abort    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        total_cnt++;
        if ({busy, in_ready, out_valid} !== 3'b000)
            $display("FAIL abort_idle: got %b want 000", {busy, in_ready, out_valid});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL abort_no_valid: got %b want 0", out_valid);
        else pass_cnt++;
        start_block(10'd1);
        push(32'h3F800000, 32'h3F800000);
        total_cnt++;
        if (out_valid !== 1'b1 || out_real !== 32'h3F800000 || out_imag !== 32'h3F800000)
            $display("FAIL abort_next_block: got %b %h %h want 1 3f800000 3f800000",
                     out_valid, out_real, out_imag);
        else pass_cnt++;
        pop();
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_back_to_back();
        test_len_zero();
        test_gaps_backpressure();
        test_reset_mid_block();
        test_consecutive();
`ifdef FLP32_CACC_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
